pdh_core: RTL and testbench
===========================

PDH_CORE -- requirements
Module: pdh_core

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high, carried as axi_from_ps_i[31] (rst).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 axi_from_ps_i  input  32  command word from PS: [31] rst (async, active-high), [30] strobe, [29:26] cmd, [25:0] data.
REQ-004 axi_to_ps_o  output  32  callback: [31:28] last executed cmd, [27] error flag, [26:0] response payload.
REQ-005 led_o  output  8  LED register.
REQ-006 dac_dat_o  output  14  DAC code.
REQ-007 dac_wrt_o  output  1  DAC write enable (level).
REQ-008 adc_dat_a_i  input  14  ADC channel A sample, two's complement.

Function
REQ-009 SHALL sync strobe through a 2-flop synchronizer and execute a command exactly once per detected rising edge; held-high strobe causes no repeat.
REQ-010 SHALL latch cmd/data with the strobe edge; axi_to_ps_o and the addressed register update within 4 clk of the strobe rising at the input.
REQ-011 cmd encoding: 0 IDLE, 1 SET_LED, 2 SET_DAC, 3 GET_ADC, 4 CHECK_SIGNED, 5 SET_ROT_COEFFS, 6 COMMIT_ROT_COEFFS, 7 GET_FRAME, 8 SET_KP, 9 SET_KD, 10 SET_KI, 11 SET_DEC, 12 SET_SP, 13 SET_ALPHA_SAT_EN; 14-15 illegal.
REQ-012 SET_LED: led_o <= data[7:0]; payload = {19'd0, data[7:0]}.
REQ-013 SET_DAC: data[15] enable, data[14] sel, data[13:0] code; stores code into dac0 (sel=0) or dac1 (sel=1), other channel kept; active channel <= sel; dac_wrt_o <= enable; payload = {11'd0, data[15:0]}.
REQ-014 With PID disabled, dac_dat_o = register of the active channel (most recently written).
REQ-015 GET_ADC: payload = {13'd0, adc_dat_a_i} sampled at execution.
REQ-016 CHECK_SIGNED: payload = adc_dat_a_i sign-extended to 27 bits.
REQ-017 SET_KP/KD/KI: 16-bit signed gain <= data[15:0]; SET_DEC: dec <= data[13:0]; SET_SP: sp (signed) <= data[13:0]; SET_ALPHA_SAT_EN: alpha <= data[9:6], sat <= data[5:1], pid_en <= data[0]; payload echoes stored field(s), zero-extended.
REQ-018 ROT/FRAME commands (5,6,7) reserved: payload 0, flag 0, no other effect.
REQ-019 IDLE: no state change; illegal cmd: [27]=1, payload 0, no register change.
REQ-020 PID update tick every max(dec,1) clk cycles (counter wraps to 0 after tick).
REQ-021 Per tick: err = sp - adc (15-bit signed); integ += err, clamped to ±(2^(sat_eff-1)-1); d = err - err_prev; df += (d - df) >>> alpha; u = kp*err + ki*integ + kd*df (48-bit signed).
REQ-022 sat_eff = clamp(sat,14,31); u clamped to sat_eff-bit signed range; pid_out = clamped u >>> (sat_eff-14), 14-bit signed.
REQ-023 With pid_en=1: dac_dat_o = pid_out (held between ticks), dac_wrt_o = 1; SET_DAC still updates registers.
REQ-024 Clearing pid_en clears integ, err_prev, df, tick counter.

Reset
REQ-025 rst=1 asynchronously: led_o=0, dac_dat_o=0, dac_wrt_o=0, axi_to_ps_o=0, dac0/dac1=0, active channel 0, all gains/sp/dec/alpha/sat=0, pid_en=0, PID state 0, strobe sync=0.
REQ-026 rst asserted mid-command aborts it; a strobe held high across reset release SHALL NOT execute.

Verification
REQ-027 Reset 10 cycles, strobe low/high/low (5 cycles each) SET_LED 0x55 -> led_o=0x55, axi_to_ps_o=0x10000055.
REQ-028 SET_DAC sel0 code 0x0123 en1 -> dac_dat_o=0x0123, dac_wrt_o=1; then sel1 0x1ABC -> 0x1ABC; then sel0 0x0005 -> 0x0005, dac1 retains 0x1ABC.
REQ-029 adc=0x2001, GET_ADC -> payload 0x0002001; CHECK_SIGNED -> payload 0x7FFE001.
REQ-030 Strobe held high 20 cycles after one edge with SET_LED 0x0F, then data changed to 0xF0 -> led_o stays 0x0F.
REQ-031 kp=0x3FFF, kd=ki=0x1FFF, dec=2, sp=0, alpha=2, sat=18, en=1, adc=0 -> dac_dat_o=0 steady; adc=-1000 -> dac_dat_o positive, saturates at 0x1FFF within bounded ticks.
REQ-032 Cmd 15 -> axi_to_ps_o=0xF8000000, registers unchanged.

Source files
------------

// File: rtl/pdh_core.sv
// pdh_core: PS command decoder with LED/DAC registers, ADC readback and a PID loop driving the DAC.
module pdh_core (
  input  logic        clk,
  input  logic [31:0] axi_from_ps_i,
  output logic [31:0] axi_to_ps_o,
  output logic [7:0]  led_o,
  output logic [13:0] dac_dat_o,
  output logic        dac_wrt_o,
  input  logic [13:0] adc_dat_a_i
);
  logic rst;
  logic [2:0] s, v;
  logic [19:0] d0, d1;
  logic go, bad, act, dac_en, pid_en, tick;
  logic [3:0] cmd, alpha;
  logic [15:0] dat;
  logic [26:0] pay;
  logic [13:0] dac0, dac1, dec, dec_last, cnt, pid_out, pid_n;
  logic [4:0] sat, sat_eff;
  logic signed [15:0] kp, kd, ki, d, df, df_n;
  logic signed [13:0] sp, adc;
  logic signed [14:0] err, err_prev;
  logic signed [31:0] integ, integ_n;
  logic signed [32:0] integ_sum, lim_i;
  logic signed [17:0] dd;
  logic signed [47:0] lim, u, u_c, sh;
  logic unused_bits;
  assign rst = axi_from_ps_i[31];
  assign cmd = d1[19:16];
  assign dat = d1[15:0];
  // v marks synchronizer stages holding post-reset samples, so a strobe high across reset release is not an edge
  assign go = s[1] & ~s[2] & v[2];
  assign adc = adc_dat_a_i;
  assign sat_eff = sat < 5'd14 ? 5'd14 : sat;
  assign lim = $signed((48'd1 << (sat_eff - 5'd1)) - 48'd1);
  assign lim_i = $signed(lim[32:0]);
  assign err = 15'(sp) - 15'(adc);
  assign integ_sum = 33'(integ) + 33'(err);
  assign integ_n = integ_sum > lim_i ? 32'(lim_i) : integ_sum < -lim_i ? 32'(-lim_i) : 32'(integ_sum);
  assign d = 16'(err) - 16'(err_prev);
  assign dd = 18'(d) - 18'(df);
  assign df_n = 16'(18'(df) + (dd >>> alpha));
  assign u = 48'(kp) * 48'(err) + 48'(ki) * 48'(integ_n) + 48'(kd) * 48'(df_n);
  assign u_c = u > lim ? lim : u < -lim - 48'sd1 ? -lim - 48'sd1 : u;
  assign sh = u_c >>> (sat_eff - 5'd14);
  assign pid_n = sh[13:0];
  assign dec_last = dec == 14'd0 ? 14'd0 : dec - 14'd1;
  assign tick = cnt >= dec_last;
  assign dac_dat_o = pid_en ? pid_out : act ? dac1 : dac0;
  assign dac_wrt_o = pid_en | dac_en;
  assign unused_bits = ^{axi_from_ps_i[25:16], sh[47:14]};
  always_comb begin
    pay = '0;
    bad = 1'b0;
    case (cmd)
      4'd1: pay = {19'd0, dat[7:0]};
      4'd2, 4'd8, 4'd9, 4'd10: pay = {11'd0, dat};
      4'd3: pay = {13'd0, adc_dat_a_i};
      4'd4: pay = {{13{adc_dat_a_i[13]}}, adc_dat_a_i};
      4'd11, 4'd12: pay = {13'd0, dat[13:0]};
      4'd13: pay = {17'd0, dat[9:0]};
      4'd14, 4'd15: bad = 1'b1;
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= '0;
      v <= '0;
      d0 <= '0;
      d1 <= '0;
      axi_to_ps_o <= '0;
      led_o <= '0;
      dac0 <= '0;
      dac1 <= '0;
      act <= 1'b0;
      dac_en <= 1'b0;
      kp <= '0;
      kd <= '0;
      ki <= '0;
      dec <= '0;
      sp <= '0;
      alpha <= '0;
      sat <= '0;
      pid_en <= 1'b0;
      cnt <= '0;
      integ <= '0;
      err_prev <= '0;
      df <= '0;
      pid_out <= '0;
    end else begin
      s <= {s[1:0], axi_from_ps_i[30]};
      v <= {v[1:0], 1'b1};
      d0 <= {axi_from_ps_i[29:26], axi_from_ps_i[15:0]};
      d1 <= d0;
      if (go) begin
        axi_to_ps_o <= {cmd, bad, pay};
        case (cmd)
          4'd1: led_o <= dat[7:0];
          4'd2: begin
            if (dat[14]) dac1 <= dat[13:0];
            else dac0 <= dat[13:0];
            act <= dat[14];
            dac_en <= dat[15];
          end
          4'd8: kp <= dat;
          4'd9: kd <= dat;
          4'd10: ki <= dat;
          4'd11: dec <= dat[13:0];
          4'd12: sp <= dat[13:0];
          4'd13: {alpha, sat, pid_en} <= dat[9:0];
          default: ;
        endcase
      end
      if (!pid_en) begin
        cnt <= '0;
        integ <= '0;
        err_prev <= '0;
        df <= '0;
      end else if (tick) begin
        cnt <= '0;
        integ <= integ_n;
        err_prev <= err;
        df <= df_n;
        pid_out <= pid_n;
      end else cnt <= cnt + 14'd1;
    end
  end
endmodule

// File: tb/tb_pdh_core.sv
// tb_pdh_core: directed-vector bench for pdh_core command handling, strobe sync and PID saturation.
module tb_pdh_core;
  logic clk = 1'b0;
  logic [31:0] axi = 32'h8000_0000;
  logic [31:0] axi_to_ps;
  logic [7:0] led;
  logic [13:0] dac;
  logic dac_wrt;
  logic [13:0] adc = '0;
  int vecs = 0;
  int errs = 0;

  pdh_core dut (
    .clk(clk),
    .axi_from_ps_i(axi),
    .axi_to_ps_o(axi_to_ps),
    .led_o(led),
    .dac_dat_o(dac),
    .dac_wrt_o(dac_wrt),
    .adc_dat_a_i(adc)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [3:0] c, input logic [25:0] d);
    @(negedge clk);
    axi = {2'b00, c, d};
    repeat (5) @(negedge clk);
    axi[30] = 1'b1;
    repeat (5) @(negedge clk);
    axi[30] = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset;
    axi = 32'h8000_0000;
    repeat (10) @(negedge clk);
    vecs += 5;
    if (led !== 8'h00) begin errs++; $display("FAIL reset_led: got %h want 00", led); end
    if (dac !== 14'h0) begin errs++; $display("FAIL reset_dac: got %h want 0000", dac); end
    if (dac_wrt !== 1'b0) begin errs++; $display("FAIL reset_wrt: got %b want 0", dac_wrt); end
    if (axi_to_ps !== 32'h0) begin errs++; $display("FAIL reset_axi: got %h want 00000000", axi_to_ps); end
    axi = 32'h0;
    repeat (5) @(negedge clk);
    if (axi_to_ps !== 32'h0) begin errs++; $display("FAIL post_reset_axi: got %h want 00000000", axi_to_ps); end
  endtask

  task automatic test_reset_held_strobe;
    axi = {2'b11, 4'd1, 26'hAA};
    repeat (3) @(negedge clk);
    axi[31] = 1'b0;
    repeat (10) @(negedge clk);
    vecs += 2;
    if (led !== 8'h00) begin errs++; $display("FAIL held_across_reset_led: got %h want 00", led); end
    if (axi_to_ps !== 32'h0) begin errs++; $display("FAIL held_across_reset_axi: got %h want 00000000", axi_to_ps); end
    axi[30] = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_led;
    axi = {2'b00, 4'd1, 26'h55};
    repeat (5) @(negedge clk);
    axi[30] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vecs += 2;
    if (axi_to_ps !== 32'h1000_0055) begin errs++; $display("FAIL led_latency_axi: got %h want 10000055", axi_to_ps); end
    if (led !== 8'h55) begin errs++; $display("FAIL led_latency_led: got %h want 55", led); end
    repeat (5) @(negedge clk);
    axi[30] = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_dac;
    send(4'd2, 26'h8123);
    vecs += 3;
    if (dac !== 14'h0123) begin errs++; $display("FAIL dac_sel0: got %h want 0123", dac); end
    if (dac_wrt !== 1'b1) begin errs++; $display("FAIL dac_wrt: got %b want 1", dac_wrt); end
    if (axi_to_ps !== 32'h2000_8123) begin errs++; $display("FAIL dac_axi: got %h want 20008123", axi_to_ps); end
    send(4'd2, 26'hDABC);
    vecs++;
    if (dac !== 14'h1ABC) begin errs++; $display("FAIL dac_sel1: got %h want 1abc", dac); end
    send(4'd2, 26'h8005);
    vecs += 2;
    if (dac !== 14'h0005) begin errs++; $display("FAIL dac_sel0_again: got %h want 0005", dac); end
    if (dut.dac1 !== 14'h1ABC) begin errs++; $display("FAIL dac1_retained: got %h want 1abc", dut.dac1); end
  endtask

  task automatic test_adc;
    adc = 14'h2001;
    send(4'd3, 26'h0);
    vecs++;
    if (axi_to_ps !== 32'h3000_2001) begin errs++; $display("FAIL get_adc: got %h want 30002001", axi_to_ps); end
    send(4'd4, 26'h0);
    vecs++;
    if (axi_to_ps !== 32'h47FF_E001) begin errs++; $display("FAIL check_signed: got %h want 47ffe001", axi_to_ps); end
    adc = 14'h0;
  endtask

  task automatic test_held_strobe;
    @(negedge clk);
    axi = {2'b00, 4'd1, 26'h0F};
    repeat (5) @(negedge clk);
    axi[30] = 1'b1;
    repeat (5) @(negedge clk);
    axi[25:0] = 26'hF0;
    repeat (15) @(negedge clk);
    vecs++;
    if (led !== 8'h0F) begin errs++; $display("FAIL held_strobe_high: got %h want 0f", led); end
    axi[30] = 1'b0;
    repeat (5) @(negedge clk);
    vecs++;
    if (led !== 8'h0F) begin errs++; $display("FAIL held_strobe_low: got %h want 0f", led); end
  endtask

  task automatic test_illegal;
    send(4'd15, 26'h3FF_FFFF);
    vecs += 3;
    if (axi_to_ps !== 32'hF800_0000) begin errs++; $display("FAIL illegal_axi: got %h want f8000000", axi_to_ps); end
    if (led !== 8'h0F) begin errs++; $display("FAIL illegal_led: got %h want 0f", led); end
    if (dac !== 14'h0005) begin errs++; $display("FAIL illegal_dac: got %h want 0005", dac); end
    send(4'd5, 26'h123);
    vecs++;
    if (axi_to_ps !== 32'h5000_0000) begin errs++; $display("FAIL reserved_axi: got %h want 50000000", axi_to_ps); end
  endtask

  task automatic test_pid;
    int n;
    send(4'd8, 26'h3FFF);
    vecs++;
    if (axi_to_ps !== 32'h8000_3FFF) begin errs++; $display("FAIL set_kp: got %h want 80003fff", axi_to_ps); end
    send(4'd9, 26'h1FFF);
    send(4'd10, 26'h1FFF);
    send(4'd11, 26'h2);
    send(4'd12, 26'h0);
    send(4'd13, 26'hA5);
    vecs++;
    if (axi_to_ps !== 32'hD000_00A5) begin errs++; $display("FAIL set_alpha_sat_en: got %h want d00000a5", axi_to_ps); end
    repeat (20) @(negedge clk);
    vecs += 2;
    if (dac !== 14'h0) begin errs++; $display("FAIL pid_zero: got %h want 0000", dac); end
    if (dac_wrt !== 1'b1) begin errs++; $display("FAIL pid_wrt: got %b want 1", dac_wrt); end
    adc = 14'h3C18;
    n = 0;
    while (dac !== 14'h1FFF && n < 100) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (dac !== 14'h1FFF) begin errs++; $display("FAIL pid_saturate: got %h want 1fff", dac); end
    repeat (10) @(negedge clk);
    vecs++;
    if (dac !== 14'h1FFF) begin errs++; $display("FAIL pid_hold: got %h want 1fff", dac); end
    send(4'd13, 26'hA4);
    vecs += 2;
    if (dac !== 14'h0005) begin errs++; $display("FAIL pid_disable_dac: got %h want 0005", dac); end
    if (axi_to_ps !== 32'hD000_00A4) begin errs++; $display("FAIL pid_disable_axi: got %h want d00000a4", axi_to_ps); end
    adc = 14'h0;
  endtask

  initial begin
    test_reset;
    test_reset_held_strobe;
    test_led;
    test_dac;
    test_adc;
    test_held_strobe;
    test_illegal;
    test_pid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
